// File: rtl/dmem_line_mem.sv
// ============================================================================
// Module   : dmem_line_mem
// Purpose  : Line-granular backing data memory for the data cache. It serves one
//            128-bit refill at a time with a fixed latency of RD_LAT cycles and
//            accepts single-cycle write-backs in every cycle.
// Options  : DMEM_STATS_EN builds saturating refill and write-back counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_line_mem #(
  parameter int LINES  = 16,
  parameter int RD_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Dc_rd_req,
  input  logic [3:0]   Dc_rd_addr,
  output logic [127:0] Dc_rline,
  output logic         Dc_rd_valid,
  input  logic         Dc_wb_we,
  input  logic [3:0]   Dc_wb_addr,
  input  logic [127:0] Dc_wb_wline,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wb_cnt
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;
  localparam logic [3:0] c_wait_init = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic [3:0]   r_pend_addr;
  logic [3:0]   w_pend_nxt;
  logic         w_enter_resp;
  logic [3:0]   w_rd_addr;
  logic [127:0] w_rd_data;
  logic         r_valid;
  logic [127:0] r_rline;
  logic [127:0] r_mem [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (Dc_rd_req) w_state_nxt = (RD_LAT == 1) ? c_st_resp : c_st_wait;
      c_st_wait: if (r_cnt == 4'd0) w_state_nxt = c_st_resp;
      c_st_resp: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_pend_nxt = r_pend_addr;
    case (r_state)
      c_st_idle: begin
        if (Dc_rd_req) begin
          w_pend_nxt = Dc_rd_addr;
          w_cnt_nxt  = c_wait_init;
        end
      end
      c_st_wait: if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
      default:   w_cnt_nxt = r_cnt;
    endcase
    w_enter_resp = (w_state_nxt == c_st_resp);
    // With RD_LAT=1 the load edge is the same edge that latches pend_addr.
    w_rd_addr = (r_state == c_st_idle) ? Dc_rd_addr : r_pend_addr;
    w_rd_data = (Dc_wb_we && (Dc_wb_addr == w_rd_addr)) ? Dc_wb_wline : r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 4'd0;
      r_pend_addr <= 4'd0;
      r_valid     <= 1'b0;
      r_rline     <= 128'd0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_pend_addr <= w_pend_nxt;
      r_valid     <= w_enter_resp;
      if (w_enter_resp) r_rline <= w_rd_data;
    end
  end

  // Storage is never cleared; writes are simply suppressed while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && Dc_wb_we) r_mem[Dc_wb_addr] <= Dc_wb_wline;
  end

  assign Dc_rd_valid = r_valid;
  assign Dc_rline    = r_rline;

`ifdef DMEM_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wb_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt <= 16'd0;
      r_wb_cnt <= 16'd0;
    end else begin
      if (w_enter_resp && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (Dc_wb_we && (r_wb_cnt != 16'hFFFF))     r_wb_cnt <= r_wb_cnt + 16'd1;
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wb_cnt = r_wb_cnt;
`else
  assign rd_cnt = 16'd0;
  assign wb_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_line_mem.sv
// ============================================================================
// Module   : tb_dmem_line_mem
// Purpose  : Directed bench for dmem_line_mem, one instance at RD_LAT=4 and
//            one at RD_LAT=1. Counter expectations follow DMEM_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_line_mem;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic         a_req = 1'b0;
  logic [3:0]   a_addr = 4'd0;
  logic [127:0] a_rline;
  logic         a_valid;
  logic         a_we = 1'b0;
  logic [3:0]   a_waddr = 4'd0;
  logic [127:0] a_wline = 128'd0;
  logic [15:0]  a_rd_cnt;
  logic [15:0]  a_wb_cnt;

  logic         b_req = 1'b0;
  logic [3:0]   b_addr = 4'd0;
  logic [127:0] b_rline;
  logic         b_valid;
  logic         b_we = 1'b0;
  logic [3:0]   b_waddr = 4'd0;
  logic [127:0] b_wline = 128'd0;
  logic [15:0]  b_rd_cnt;
  logic [15:0]  b_wb_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] P5  = {32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [127:0] P7  = {4{32'h1111_1111}};
  localparam logic [127:0] PA5 = {16{8'hA5}};
  localparam logic [127:0] P9  = {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000};
  localparam logic [127:0] P1  = {4{32'h0101_0101}};
  localparam logic [127:0] P10 = {4{32'hAAAA_0010}};
  localparam logic [127:0] P11 = {4{32'hBBBB_0011}};
  localparam logic [127:0] P2  = {4{32'h2222_2222}};
  localparam logic [127:0] P3  = {4{32'h3333_3333}};

`ifdef DMEM_STATS_EN
  localparam logic [15:0] EXP_RD = 16'd3;
  localparam logic [15:0] EXP_WB = 16'd2;
`else
  localparam logic [15:0] EXP_RD = 16'd0;
  localparam logic [15:0] EXP_WB = 16'd0;
`endif

  always #5 clk = ~clk;

  dmem_line_mem #(.LINES(16), .RD_LAT(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .Dc_rd_req(a_req), .Dc_rd_addr(a_addr), .Dc_rline(a_rline), .Dc_rd_valid(a_valid),
    .Dc_wb_we(a_we), .Dc_wb_addr(a_waddr), .Dc_wb_wline(a_wline),
    .rd_cnt(a_rd_cnt), .wb_cnt(a_wb_cnt)
  );

  dmem_line_mem #(.LINES(16), .RD_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .Dc_rd_req(b_req), .Dc_rd_addr(b_addr), .Dc_rline(b_rline), .Dc_rd_valid(b_valid),
    .Dc_wb_we(b_we), .Dc_wb_addr(b_waddr), .Dc_wb_wline(b_wline),
    .rd_cnt(b_rd_cnt), .wb_cnt(b_wb_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input logic [3:0] addr, input logic [127:0] data);
    a_we = 1'b1; a_waddr = addr; a_wline = data;
    @(negedge clk);
    a_we = 1'b0;
  endtask

  // Request issued in cycle 0; valid must pulse only in cycle 4 with exp_line.
  task automatic a_refill(input string tag, input logic [3:0] addr, input logic [127:0] exp_line);
    a_req = 1'b1; a_addr = addr;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("%s_valid_c%0d", tag, k), {127'd0, a_valid}, {127'd0, (k == 4)});
      if (k == 4) begin
        chk($sformatf("%s_line", tag), a_rline, exp_line);
        a_req = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset held for 3 cycles.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid_in", {127'd0, a_valid}, 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", {127'd0, a_valid}, 128'd0);
    chk("rst_rline", a_rline, 128'd0);
    chk("rst_b_valid", {127'd0, b_valid}, 128'd0);

    // Basic write-back then refill.
    a_write(4'd5, P5);
    a_refill("basic", 4'd5, P5);

    // Collision: write-back lands on the edge entering RESP.
    a_write(4'd7, P7);
    a_req = 1'b1; a_addr = 4'd7;
    repeat (3) @(negedge clk);
    chk("coll_valid_c3", {127'd0, a_valid}, 128'd0);
    a_we = 1'b1; a_waddr = 4'd7; a_wline = PA5;
    @(negedge clk);
    a_we = 1'b0; a_req = 1'b0;
    chk("coll_valid_c4", {127'd0, a_valid}, 128'd1);
    chk("coll_line", a_rline, PA5);
    @(negedge clk);
    chk("coll_valid_c5", {127'd0, a_valid}, 128'd0);
    a_refill("coll_mem", 4'd7, PA5);

    // Request instability during WAIT.
    a_write(4'd9, P9);
    a_write(4'd1, P1);
    a_req = 1'b1; a_addr = 4'd9;
    @(negedge clk);
    a_req = 1'b0; a_addr = 4'd1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("instab_valid_c%0d", k), {127'd0, a_valid}, {127'd0, (k == 4)});
      if (k == 4) chk("instab_line", a_rline, P9);
    end

    // Reset asserted in cycle 2 of a refill drops it.
    a_req = 1'b1; a_addr = 4'd5;
    repeat (2) @(negedge clk);
    rst = 1'b0; a_req = 1'b0;
    #1;
    chk("midrst_valid_async", {127'd0, a_valid}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_valid_c%0d", k), {127'd0, a_valid}, 128'd0);
    end
    chk("midrst_rdcnt", {112'd0, a_rd_cnt}, 128'd0);

    // Two write-backs and three refills after reset.
    a_write(4'd10, P10);
    a_write(4'd11, P11);
    a_refill("post10", 4'd10, P10);
    a_refill("post11", 4'd11, P11);
    a_refill("post5", 4'd5, P5);
    chk("stat_rd_cnt", {112'd0, a_rd_cnt}, {112'd0, EXP_RD});
    chk("stat_wb_cnt", {112'd0, a_wb_cnt}, {112'd0, EXP_WB});

    // RD_LAT=1 back-to-back refills.
    b_we = 1'b1; b_waddr = 4'd2; b_wline = P2;
    @(negedge clk);
    b_waddr = 4'd3; b_wline = P3;
    @(negedge clk);
    b_we = 1'b0;
    b_req = 1'b1; b_addr = 4'd2;
    @(negedge clk);
    chk("lat1_valid_c1", {127'd0, b_valid}, 128'd1);
    chk("lat1_line2", b_rline, P2);
    b_addr = 4'd3;
    @(negedge clk);
    chk("lat1_valid_c2", {127'd0, b_valid}, 128'd0);
    @(negedge clk);
    chk("lat1_valid_c3", {127'd0, b_valid}, 128'd1);
    chk("lat1_line3", b_rline, P3);
    b_req = 1'b0;
    @(negedge clk);
    chk("lat1_valid_c4", {127'd0, b_valid}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_line_mem.md
# dmem_line_mem

Line-granular backing data memory directly downstream of the data cache. It serves one 128-bit line refill at a time with a fixed, parameterised read latency. It also absorbs single-cycle dirty-line write-backs at any time, including while a refill is in flight. Address space is 16 lines (4-bit line address); word `k` of a line occupies bits `[32k+31:32k]`.

## Interface

Parameters:
- `LINES`, 16: number of 128-bit lines; the line address width is fixed at 4.
- `RD_LAT`, 4: refill latency in cycles. Legal range is 1..15.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `Dc_rd_req`, in, 1: refill request. Held high by the cache until it sees `Dc_rd_valid`.
- `Dc_rd_addr`, in, 4: line address of the refill.
- `Dc_rline`, out, 128: refill data. Registered; meaningful only while `Dc_rd_valid` is high.
- `Dc_rd_valid`, out, 1: one-cycle pulse marking refill data valid. Registered.
- `Dc_wb_we`, in, 1: write-back strobe, one cycle per line.
- `Dc_wb_addr`, in, 4: write-back line address.
- `Dc_wb_wline`, in, 128: write-back line data.
- `rd_cnt`, out, 16: refills completed. Statistics only; see Configuration.
- `wb_cnt`, out, 16: write-backs accepted. Statistics only; see Configuration.

## Operation

- Storage is `LINES` x 128 bit. Contents are not cleared by reset and are undefined after power-up.
- FSM states:
  - **IDLE**: when `Dc_rd_req`=1, latch `Dc_rd_addr` into `pend_addr`. Go to **RESP** if `RD_LAT`=1, otherwise go to **WAIT** with `cnt`=`RD_LAT`-2.
  - **WAIT**: decrement `cnt`. When `cnt`=0, go to **RESP**.
  - **RESP**: `Dc_rd_valid`=1 for exactly this one cycle, then return unconditionally to **IDLE**.
- `Dc_rline` is loaded from `mem[pend_addr]` on the edge that enters **RESP**.
- Write-back behaviour:
  - Accepted in every state with no handshake: `mem[Dc_wb_addr]` <= `Dc_wb_wline` on the edge where `Dc_wb_we`=1.
  - A write-back never stalls or delays a refill.
- Write-back/refill collision: if `Dc_wb_we`=1 and `Dc_wb_addr`=`pend_addr` on the edge that loads `Dc_rline`, then `Dc_rline` takes `Dc_wb_wline`. Refill data never returns stale data.
- Request handling:
  - Requests are sampled only in **IDLE**.
  - `Dc_rd_req` and `Dc_rd_addr` are ignored in **WAIT** and **RESP**.
  - An address change or request drop mid-flight does not abort the refill; the refill for `pend_addr` still completes.
- Re-request after completion: when `Dc_rd_req` is high in the **IDLE** cycle directly after **RESP**, a new refill starts. No extra bubble is inserted.

## Timing

- Refill latency: request first seen in **IDLE** in cycle 0 → `Dc_rd_valid` high in cycle `RD_LAT`.
- Minimum spacing between back-to-back refills is `RD_LAT`+1 cycles.
- Write-to-read ordering: data written on edge E is visible to any refill whose `Dc_rline` load edge is at or after E.
- Reset while `rst`=0, applied asynchronously:
  - FSM=**IDLE**, `cnt`=0, `pend_addr`=0.
  - `Dc_rd_valid`=0, `Dc_rline`=0.
  - `rd_cnt`=0, `wb_cnt`=0.
- Reset asserted mid-refill: the refill is dropped and no valid pulse is issued.
- Write-back presented while `rst`=0: ignored.

## Configuration

- `DMEM_STATS_EN` defined:
  - `rd_cnt` increments on each edge that enters **RESP**.
  - `wb_cnt` increments on each accepted write-back.
  - Both counters saturate at 16'hFFFF and never wrap.
- `DMEM_STATS_EN` undefined: `rd_cnt` and `wb_cnt` are tied to 0, and no counter registers are built.

## Test plan

- Reset check, `RD_LAT`=4: hold `rst`=0 for 3 cycles, release → `Dc_rd_valid`=0, `Dc_rline`=0, FSM in **IDLE**.
- Basic write-back then refill:
  - Stimulus: write-back to line 5 with data {32'h4,32'h3,32'h2,32'h1}, then assert `Dc_rd_req` with addr 5 at cycle 0.
  - Required response: `Dc_rd_valid` high only in cycle 4, with that line on `Dc_rline`.
- `RD_LAT`=1 back-to-back: `Dc_rd_req` to line 2 in cycle 0 → valid in cycle 1; a new request to line 3 in cycle 2 → valid in cycle 3.
- Collision: a write-back to line 7 with 128'hA5..A5 lands on the same edge that loads the refill of line 7 → `Dc_rline`=128'hA5..A5.
- Request instability: request line 9, then drop `Dc_rd_req` and drive addr 1 during **WAIT** → valid still pulses in cycle `RD_LAT` carrying line 9.
- Reset and statistics:
  - Assert `rst`=0 in cycle 2 of a refill → no valid pulse; the next request completes normally.
  - With `DMEM_STATS_EN`: 3 refills and 2 write-backs → `rd_cnt`=3, `wb_cnt`=2.
